ltc2656_sequencer: RTL and testbench

Command sequencer that sits directly upstream of the LTC-2656 SPI driver. It buffers DAC channel-update requests in a small FIFO and issues each one to the driver as a single-cycle transfer command, after waiting for the driver to report idle. It optionally follows the last entry of a batch with an LDAC pulse, and forwards asynchronous clear requests to the driver at the next safe boundary.

---
 rtl/ltc2656_pkg.sv | 31 +++
 rtl/ltc2656_sequencer_fifo.sv | 47 ++++
 rtl/ltc2656_sequencer.sv | 103 ++++++++++
 tb/tb_ltc2656_sequencer.sv | 379 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ltc2656_pkg.sv
// Shared constants and types for the LTC-2656 command path: driver command
// codes, DAC command nibbles, sequencer states and the queued request layout.
package ltc2656_pkg;

  localparam logic [1:0] CMD_NONE = 2'd0;
  localparam logic [1:0] CMD_XFER = 2'd1;
  localparam logic [1:0] CMD_LDAC = 2'd2;
  localparam logic [1:0] CMD_CLR  = 2'd3;

  localparam logic [3:0] NIB_WRITE_INPUT  = 4'h0;
  localparam logic [3:0] NIB_UPDATE       = 4'h1;
  localparam logic [3:0] NIB_WRITE_UPDATE = 4'h3;
  localparam logic [3:0] NIB_POWER_DOWN   = 4'h4;

  typedef enum logic [1:0] {
    S_IDLE,
    S_SETTLE,
    S_WAIT,
    S_LDAC
  } seq_state_t;

  typedef struct packed {
    logic        last;
    logic [3:0]  cmd;
    logic [3:0]  channel;
    logic [15:0] value;
  } dac_req_t;

  localparam int REQ_WIDTH = $bits(dac_req_t);

endpackage

// File: rtl/ltc2656_sequencer_fifo.sv
// Generic synchronous FIFO with one extra pointer bit so full and empty are
// distinguishable; occupancy is derived combinationally from the pointers.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                   clk,
  input  logic                   resetn,
  input  logic                   push,
  input  logic [WIDTH-1:0]       push_data,
  input  logic                   pop,
  output logic [WIDTH-1:0]       pop_data,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push && !full)
        wr_ptr <= wr_ptr + 1'b1;
      if (pop && !empty)
        rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Storage is not reset; a flush only needs the pointers cleared.
  always_ff @(posedge clk) begin
    if (push && !full)
      mem[wr_ptr[AW-1:0]] <= push_data;
  end

  assign count    = wr_ptr - rd_ptr;
  assign full     = (count == (AW + 1)'(DEPTH));
  assign empty    = (wr_ptr == rd_ptr);
  assign pop_data = mem[rd_ptr[AW-1:0]];

endmodule

// File: rtl/ltc2656_sequencer.sv
// Queues DAC channel updates and hands them to the LTC-2656 SPI driver one at a
// time, adding an LDAC after batch ends and forwarding CLR at safe boundaries.
module ltc2656_sequencer
  import ltc2656_pkg::*;
#(
  parameter int FIFO_DEPTH = 16,
  parameter bit AUTO_LDAC  = 1'b1
) (
  input  logic                        clk,
  input  logic                        resetn,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [3:0]                  in_cmd,
  input  logic [3:0]                  in_channel,
  input  logic [15:0]                 in_value,
  input  logic                        in_last,
  input  logic                        clr_req,
  input  logic                        drv_idle,
  output logic [1:0]                  drv_command,
  output logic [3:0]                  drv_cmd,
  output logic [3:0]                  drv_channel,
  output logic [15:0]                 drv_value,
  output logic                        busy,
  output logic [$clog2(FIFO_DEPTH):0] fifo_count
);

  seq_state_t state;
  dac_req_t   in_req;
  dac_req_t   head;
  logic       fifo_full;
  logic       fifo_empty;
  logic       pop;
  logic       clr_pending;
  logic       ldac_due;

  assign in_req   = {in_last, in_cmd, in_channel, in_value};
  assign in_ready = !fifo_full;
  assign pop      = (state == S_IDLE) && drv_idle && !clr_pending && !fifo_empty;
  assign busy     = (state != S_IDLE) || !fifo_empty || clr_pending;

  sync_fifo #(
    .WIDTH (REQ_WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .resetn    (resetn),
    .push      (in_valid && in_ready),
    .push_data (in_req),
    .pop       (pop),
    .pop_data  (head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  // A CLR raised while one is already pending merges into it; issuing the CLR
  // is the only thing that retires the pending flag.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state       <= S_IDLE;
      drv_command <= CMD_NONE;
      drv_cmd     <= '0;
      drv_channel <= '0;
      drv_value   <= '0;
      clr_pending <= 1'b0;
      ldac_due    <= 1'b0;
    end else begin
      drv_command <= CMD_NONE;
      if (clr_req)
        clr_pending <= 1'b1;

      case (state)
        S_IDLE: begin
          if (drv_idle && clr_pending) begin
            drv_command <= CMD_CLR;
            clr_pending <= 1'b0;
            state       <= S_SETTLE;
          end else if (pop) begin
            drv_command <= CMD_XFER;
            drv_cmd     <= head.cmd;
            drv_channel <= head.channel;
            drv_value   <= head.value;
            ldac_due    <= AUTO_LDAC && head.last;
            state       <= S_SETTLE;
          end
        end
        // drv_idle is stale in the cycle right after a command pulse.
        S_SETTLE: state <= S_WAIT;
        S_WAIT: begin
          if (drv_idle)
            state <= ldac_due ? S_LDAC : S_IDLE;
        end
        S_LDAC: begin
          drv_command <= CMD_LDAC;
          ldac_due    <= 1'b0;
          state       <= S_SETTLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ltc2656_sequencer.sv
// Self-checking bench: table vectors, hand-built corner sequences and random
// traffic compared against an ordered command-stream model.
module tb_ltc2656_sequencer;
  import ltc2656_pkg::*;

  localparam int DEPTH = 16;

  typedef struct {
    logic [1:0]  command;
    logic [3:0]  cmd;
    logic [3:0]  ch;
    logic [15:0] val;
    int          cyc;
  } ev_t;

  typedef struct {
    logic [3:0]  cmd;
    logic [3:0]  channel;
    logic [15:0] value;
    logic        last;
    int          exp_latency;
    int          exp_pulses;
    logic [1:0]  exp_second;
  } vec_t;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [3:0]  in_cmd = '0;
  logic [3:0]  in_channel = '0;
  logic [15:0] in_value = '0;
  logic        in_last = 1'b0;
  logic        clr_req = 1'b0;
  logic        drv_idle;
  logic [1:0]  drv_command;
  logic [3:0]  drv_cmd;
  logic [3:0]  drv_channel;
  logic [15:0] drv_value;
  logic        busy;
  logic [4:0]  fifo_count;

  always #5 clk = ~clk;

  ltc2656_sequencer #(
    .FIFO_DEPTH (DEPTH),
    .AUTO_LDAC  (1'b1)
  ) dut (
    .clk         (clk),
    .resetn      (resetn),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_cmd      (in_cmd),
    .in_channel  (in_channel),
    .in_value    (in_value),
    .in_last     (in_last),
    .clr_req     (clr_req),
    .drv_idle    (drv_idle),
    .drv_command (drv_command),
    .drv_cmd     (drv_cmd),
    .drv_channel (drv_channel),
    .drv_value   (drv_value),
    .busy        (busy),
    .fifo_count  (fifo_count)
  );

  // Driver model: goes busy for xfer_len cycles once it sees any command.
  int   xfer_len = 0;
  logic idle_hold = 1'b0;
  int   drv_busy_cnt = 0;
  always @(posedge clk) begin
    if (drv_command != CMD_NONE)
      drv_busy_cnt <= xfer_len;
    else if (drv_busy_cnt > 0)
      drv_busy_cnt <= drv_busy_cnt - 1;
  end
  assign drv_idle = (drv_busy_cnt == 0) && !idle_hold;

  int   cyc = 0;
  logic rst_q = 1'b1;
  logic prev_idle = 1'b1;
  int   acc_total = 0;
  always @(posedge clk) begin
    cyc       <= cyc + 1;
    rst_q     <= !resetn;
    prev_idle <= drv_idle;
    if (!resetn)
      acc_total <= 0;
    else if (in_valid && in_ready)
      acc_total <= acc_total + 1;
  end

  ev_t         log_q[$];
  int          xfer_total = 0;
  int          last_issue = -100;
  int          count_viol = 0, ready_viol = 0, idle_viol = 0, spacing_viol = 0, hold_viol = 0;
  logic [23:0] prev_fields = '0;

  always @(negedge clk) begin
    if (rst_q) begin
      xfer_total  = 0;
      last_issue  = -100;
      prev_fields = {drv_cmd, drv_channel, drv_value};
    end else begin
      if (drv_command != CMD_NONE) begin
        log_q.push_back('{drv_command, drv_cmd, drv_channel, drv_value, cyc});
        if (cyc - last_issue < 3) spacing_viol++;
        if (!prev_idle) idle_viol++;
        last_issue = cyc;
        if (drv_command == CMD_XFER) xfer_total++;
      end
      if (drv_command != CMD_XFER && {drv_cmd, drv_channel, drv_value} !== prev_fields)
        hold_viol++;
      prev_fields = {drv_cmd, drv_channel, drv_value};
      if (fifo_count !== 5'(acc_total - xfer_total)) count_viol++;
      if (in_ready !== ((acc_total - xfer_total) < DEPTH)) ready_viol++;
    end
  end

  int checks = 0;
  int passes = 0;

  task automatic check_value(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  dac_req_t sent_q[$];
  ev_t      exp_q[$];

  function automatic ev_t mk_ev(input logic [1:0] c, input dac_req_t r);
    ev_t e;
    e.command = c; e.cmd = r.cmd; e.ch = r.channel; e.val = r.value; e.cyc = 0;
    return e;
  endfunction

  function automatic logic [25:0] ev_bits(input ev_t e);
    return {e.command, e.cmd, e.ch, e.val};
  endfunction

  function automatic dac_req_t rand_req(input bit allow_last);
    dac_req_t r;
    r.cmd = 4'($urandom); r.channel = 4'($urandom); r.value = 16'($urandom);
    r.last = allow_last ? ($urandom_range(0, 3) == 0) : 1'b0;
    return r;
  endfunction

  task automatic clear_logs();
    log_q.delete(); sent_q.delete(); exp_q.delete();
  endtask

  // Called on a negedge; returns on the negedge after the accepting edge.
  task automatic push(input dac_req_t r);
    int guard = 0;
    in_valid = 1'b1; in_last = r.last; in_cmd = r.cmd; in_channel = r.channel; in_value = r.value;
    while (!in_ready && guard < 5000) begin
      @(negedge clk);
      guard++;
    end
    if (!in_ready) check_value("push ready timeout", in_ready, 1'b1);
    else begin
      @(negedge clk);
      sent_q.push_back(r);
    end
    in_valid = 1'b0;
  endtask

  task automatic wait_quiet(input string tag, input int budget);
    int n = 0;
    tick(2);
    while (busy && n < budget) begin
      @(negedge clk);
      n++;
    end
    check_value({tag, " drains"}, busy, 1'b0);
    tick(2);
  endtask

  task automatic wait_for_log(input int n, input int budget);
    int k = 0;
    while (log_q.size() < n && k < budget) begin
      @(negedge clk);
      k++;
    end
    if (log_q.size() < n) check_value("wait for pulse timeout", log_q.size(), n);
  endtask

  // Each accepted request yields an XFER, followed by an LDAC when it ends a batch.
  task automatic expect_from_sent();
    foreach (sent_q[i]) begin
      exp_q.push_back(mk_ev(CMD_XFER, sent_q[i]));
      if (sent_q[i].last) exp_q.push_back(mk_ev(CMD_LDAC, sent_q[i]));
    end
  endtask

  task automatic compare_log(input string tag);
    check_value({tag, " pulse count"}, log_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < log_q.size(); i++)
      check_value($sformatf("%s pulse %0d", tag, i), ev_bits(log_q[i]), ev_bits(exp_q[i]));
  endtask

  vec_t vecs[4];

  initial begin
    dac_req_t r;
    dac_req_t r1;
    int       acc_cyc;

    vecs[0] = '{4'h3, 4'h2, 16'hABCD, 1'b0, 1, 1, CMD_NONE};
    vecs[1] = '{4'h0, 4'h5, 16'h0001, 1'b1, 1, 2, CMD_LDAC};
    vecs[2] = '{4'h4, 4'hF, 16'hFFFF, 1'b0, 1, 1, CMD_NONE};
    vecs[3] = '{4'h1, 4'h0, 16'h8000, 1'b1, 1, 2, CMD_LDAC};

    resetn = 1'b0;
    tick(3);
    check_value("reset drv_command", drv_command, CMD_NONE);
    check_value("reset drv_cmd", drv_cmd, 4'h0);
    check_value("reset drv_channel", drv_channel, 4'h0);
    check_value("reset drv_value", drv_value, 16'h0);
    check_value("reset busy", busy, 1'b0);
    check_value("reset fifo_count", fifo_count, 5'd0);
    check_value("reset in_ready", in_ready, 1'b1);
    resetn = 1'b1;
    tick(2);

    // Single requests against a fast driver.
    xfer_len = 4;
    for (int i = 0; i < 4; i++) begin
      clear_logs();
      r = '{last: vecs[i].last, cmd: vecs[i].cmd, channel: vecs[i].channel, value: vecs[i].value};
      push(r);
      acc_cyc = cyc;
      check_value($sformatf("vec%0d busy after accept", i), busy, 1'b1);
      wait_quiet($sformatf("vec%0d", i), 500);
      check_value($sformatf("vec%0d pulses", i), log_q.size(), vecs[i].exp_pulses);
      if (log_q.size() > 0) begin
        check_value($sformatf("vec%0d xfer", i), ev_bits(log_q[0]), ev_bits(mk_ev(CMD_XFER, r)));
        check_value($sformatf("vec%0d latency", i), log_q[0].cyc - acc_cyc, vecs[i].exp_latency);
      end
      if (log_q.size() > 1) begin
        check_value($sformatf("vec%0d second", i), ev_bits(log_q[1]), ev_bits(mk_ev(vecs[i].exp_second, r)));
        check_value($sformatf("vec%0d ldac waits", i), (log_q[1].cyc - log_q[0].cyc) >= xfer_len + 2, 1'b1);
      end
    end

    // Fill the FIFO while the driver is held busy, then drain with slow transfers.
    clear_logs();
    idle_hold = 1'b1;
    xfer_len  = 60;
    for (int i = 0; i < DEPTH; i++) push(rand_req(1'b0));
    check_value("burst full count", fifo_count, 5'd16);
    check_value("burst in_ready low", in_ready, 1'b0);
    in_valid = 1'b1; in_value = 16'h5555;
    tick(1);
    in_valid = 1'b0;
    check_value("burst push when full ignored", fifo_count, 5'd16);
    idle_hold = 1'b0;
    wait_quiet("burst", 3000);
    expect_from_sent();
    compare_log("burst");
    check_value("burst drained count", fifo_count, 5'd0);

    // Three-entry batch: LDAC only after the last one.
    clear_logs();
    xfer_len = 5;
    for (int i = 0; i < 3; i++) begin
      r = rand_req(1'b0);
      r.last = (i == 2);
      push(r);
    end
    wait_quiet("batch", 500);
    expect_from_sent();
    compare_log("batch");
    if (log_q.size() >= 4)
      check_value("batch ldac after xfer3", (log_q[3].cyc - log_q[2].cyc) >= xfer_len + 2, 1'b1);

    // Two CLR pulses during a transfer merge into one CLR ahead of the queue.
    clear_logs();
    xfer_len  = 20;
    idle_hold = 1'b1;
    for (int i = 0; i < 3; i++) push(rand_req(1'b0));
    idle_hold = 1'b0;
    wait_for_log(1, 200);
    tick(3);
    clr_req = 1'b1; tick(1); clr_req = 1'b0;
    tick(4);
    clr_req = 1'b1; tick(1); clr_req = 1'b0;
    wait_quiet("clr", 1000);
    exp_q.push_back(mk_ev(CMD_XFER, sent_q[0]));
    exp_q.push_back(mk_ev(CMD_CLR, sent_q[0]));
    exp_q.push_back(mk_ev(CMD_XFER, sent_q[1]));
    exp_q.push_back(mk_ev(CMD_XFER, sent_q[2]));
    compare_log("clr");
    if (log_q.size() >= 2)
      check_value("clr waits for xfer", (log_q[1].cyc - log_q[0].cyc) >= xfer_len + 2, 1'b1);

    // CLR arriving on the XFER issue cycle waits for the XFER and its owed LDAC.
    clear_logs();
    xfer_len  = 3;
    idle_hold = 1'b1;
    r = rand_req(1'b0);
    r.last = 1'b1;
    push(r);
    idle_hold = 1'b0;
    clr_req   = 1'b1;
    tick(1);
    clr_req = 1'b0;
    wait_quiet("clr coincident", 500);
    expect_from_sent();
    exp_q.push_back(mk_ev(CMD_CLR, r));
    compare_log("clr coincident");

    // Reset in the middle of a burst flushes everything.
    clear_logs();
    xfer_len  = 30;
    idle_hold = 1'b1;
    for (int i = 0; i < 6; i++) push(rand_req(1'b0));
    idle_hold = 1'b0;
    wait_for_log(1, 200);
    tick(5);
    check_value("midreset queued", fifo_count, 5'd5);
    resetn = 1'b0;
    tick(1);
    resetn = 1'b1;
    check_value("midreset fifo_count", fifo_count, 5'd0);
    check_value("midreset drv_command", drv_command, CMD_NONE);
    check_value("midreset drv fields", {drv_cmd, drv_channel, drv_value}, 24'h0);
    check_value("midreset busy", busy, 1'b0);
    check_value("midreset in_ready", in_ready, 1'b1);
    log_q.delete();
    tick(100);
    check_value("midreset no pulses", log_q.size(), 0);

    // Simultaneous push and pop at occupancy one.
    clear_logs();
    xfer_len  = 3;
    idle_hold = 1'b1;
    r = rand_req(1'b0);
    push(r);
    check_value("pushpop count before", fifo_count, 5'd1);
    r1 = rand_req(1'b0);
    in_valid = 1'b1; in_last = r1.last; in_cmd = r1.cmd; in_channel = r1.channel; in_value = r1.value;
    idle_hold = 1'b0;
    tick(1);
    in_valid = 1'b0;
    sent_q.push_back(r1);
    check_value("pushpop count same", fifo_count, 5'd1);
    wait_quiet("pushpop", 500);
    expect_from_sent();
    compare_log("pushpop");

    // Random traffic across three pointer wraps.
    clear_logs();
    for (int i = 0; i < 3 * DEPTH; i++) begin
      tick($urandom_range(0, 2));
      xfer_len = $urandom_range(0, 6);
      push(rand_req(1'b1));
    end
    wait_quiet("random", 5000);
    expect_from_sent();
    compare_log("random");
    check_value("random drained count", fifo_count, 5'd0);

    check_value("fifo_count tracking", count_viol, 0);
    check_value("in_ready tracking", ready_viol, 0);
    check_value("issue only when idle", idle_viol, 0);
    check_value("issue spacing", spacing_viol, 0);
    check_value("fields hold outside xfer", hold_viol, 0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
